pdn_rail_sequencer: RTL and testbench



---
 rtl/pdn_seq_pkg.sv | 23 ++
 rtl/pdn_pgood_sync.sv | 25 ++
 rtl/pdn_rail_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pdn_rail_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdn_seq_pkg.sv
// Shared types and constants for the power-rail sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package pdn_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_UP_WAIT,
        ST_SETTLE,
        ST_ON,
        ST_DOWN_WAIT,
        ST_FAULT
    } pdn_seq_state_e;

    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_TIMEOUT_W  = 16;

    // Rail index width; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pdn_pgood_sync.sv
// Two-flop synchronizer for asynchronous power-good inputs, reset to 0.
// Latency: 2 cycles from din to dout.
// Backpressure: none; samples every cycle.
module pdn_pgood_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/pdn_rail_sequencer.sv
// Rail sequencer: ramps rails up in ascending order, down in descending order, gated by pgood with timeout.
// Latency: rail_en follows a sampled request/pgood by 1 cycle (+2 with PDN_SEQ_PGOOD_SYNC_EN defined).
// Backpressure: none; each step stalls on rail_pgood until it arrives or the timeout expires.
module pdn_rail_sequencer
    import pdn_seq_pkg::*;
#(
    parameter int NUM_RAILS  = 6,
    parameter int TIMEOUT_W  = DEF_TIMEOUT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           power_up_req,
    input  logic                           power_down_req,
    input  logic                           clr_fault,
    input  logic [TIMEOUT_W-1:0]           timeout_cycles,
    input  logic [NUM_RAILS-1:0]           rail_pgood,
    output logic [NUM_RAILS-1:0]           rail_en,
    output logic                           rails_on,
    output logic                           busy,
    output logic                           fault,
    output logic [idx_w(NUM_RAILS)-1:0]    fault_rail
);

    localparam int                   IW          = idx_w(NUM_RAILS);
    localparam logic [IW-1:0]        LAST_IDX    = IW'(NUM_RAILS - 1);
    localparam logic [TIMEOUT_W-1:0] SETTLE_LAST = TIMEOUT_W'(SETTLE_CYC - 1);

    pdn_seq_state_e         state, state_n;
    logic [IW-1:0]          idx, idx_n, idx_p1, idx_m1, low_bad, frail_n;
    logic [TIMEOUT_W-1:0]   cnt, cnt_n, cnt_inc, t_eff;
    logic [NUM_RAILS-1:0]   pgood, en_n;
    logic                   fault_n, pg_cur, timed_out;

`ifdef PDN_SEQ_PGOOD_SYNC_EN
    pdn_pgood_sync #(
        .WIDTH (NUM_RAILS)
    ) u_pgood_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rail_pgood),
        .dout (pgood)
    );
`else
    assign pgood = rail_pgood;
`endif

    // A zero timeout means "as long as the counter allows".
    assign t_eff     = (timeout_cycles == '0) ? '1 : timeout_cycles;
    assign cnt_inc   = cnt + 1'b1;
    assign timed_out = (cnt >= t_eff - 1'b1);
    assign idx_p1    = idx + 1'b1;
    assign idx_m1    = idx - 1'b1;
    assign pg_cur    = pgood[idx];

    always_comb begin
        low_bad = '0;
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (!pgood[i]) low_bad = IW'(i);
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        en_n    = rail_en;
        fault_n = fault;
        frail_n = fault_rail;
        case (state)
            ST_OFF: begin
                if (power_up_req) begin
                    state_n = ST_UP_WAIT;
                    idx_n   = '0;
                    cnt_n   = '0;
                    en_n    = '0;
                    en_n[0] = 1'b1;
                end
            end
            ST_UP_WAIT: begin
                if (!pg_cur && timed_out) begin
                    state_n = ST_FAULT;
                    en_n    = '0;
                    fault_n = 1'b1;
                    frail_n = idx;
                end else if (power_down_req) begin
                    state_n   = ST_DOWN_WAIT;
                    en_n[idx] = 1'b0;
                    cnt_n     = '0;
                end else if (pg_cur) begin
                    state_n = ST_SETTLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_SETTLE: begin
                if (!pg_cur) begin
                    state_n = ST_FAULT;
                    en_n    = '0;
                    fault_n = 1'b1;
                    frail_n = idx;
                end else if (power_down_req) begin
                    state_n   = ST_DOWN_WAIT;
                    en_n[idx] = 1'b0;
                    cnt_n     = '0;
                end else if (cnt == SETTLE_LAST) begin
                    cnt_n = '0;
                    if (idx == LAST_IDX) begin
                        state_n = ST_ON;
                    end else begin
                        state_n      = ST_UP_WAIT;
                        idx_n        = idx_p1;
                        en_n[idx_p1] = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_ON: begin
                // A collapsing rail outranks a concurrent power-down request.
                if (pgood != '1) begin
                    state_n = ST_FAULT;
                    en_n    = '0;
                    fault_n = 1'b1;
                    frail_n = low_bad;
                end else if (power_down_req) begin
                    state_n        = ST_DOWN_WAIT;
                    idx_n          = LAST_IDX;
                    en_n[LAST_IDX] = 1'b0;
                    cnt_n          = '0;
                end
            end
            ST_DOWN_WAIT: begin
                if (!pg_cur) begin
                    cnt_n = '0;
                    if (idx == '0) begin
                        state_n = ST_OFF;
                    end else begin
                        idx_n        = idx_m1;
                        en_n[idx_m1] = 1'b0;
                    end
                end else if (timed_out) begin
                    state_n = ST_FAULT;
                    en_n    = '0;
                    fault_n = 1'b1;
                    frail_n = idx;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_FAULT: begin
                en_n = '0;
                if (clr_fault && !power_up_req) begin
                    state_n = ST_OFF;
                    fault_n = 1'b0;
                    frail_n = '0;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = ST_OFF;
                en_n    = '0;
                idx_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_OFF;
            idx        <= '0;
            cnt        <= '0;
            rail_en    <= '0;
            rails_on   <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            fault_rail <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            rail_en    <= en_n;
            rails_on   <= (state_n == ST_ON);
            busy       <= (state_n == ST_UP_WAIT) || (state_n == ST_SETTLE) ||
                          (state_n == ST_DOWN_WAIT);
            fault      <= fault_n;
            fault_rail <= frail_n;
        end
    end

endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// Bench for pdn_rail_sequencer: each expected output change is queued with its cycle distance from the
// previous change; a monitor compares every observed change of {rail_en, rails_on, busy, fault, fault_rail}.
module tb_pdn_rail_sequencer;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         power_up_req;
    logic         power_down_req;
    logic         clr_fault;
    logic [15:0]  timeout_cycles;
    logic [N-1:0] rail_pgood;
    logic [N-1:0] rail_en;
    logic         rails_on;
    logic         busy;
    logic         fault;
    logic [2:0]   fault_rail;

    logic [N-1:0]        stuck;
    logic [N-1:0]        glitch;
    logic [2:0][N-1:0]   hist;
    logic                mon_en = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [11:0] val;
        int          dly;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pdn_rail_sequencer #(
        .NUM_RAILS  (N),
        .TIMEOUT_W  (16),
        .SETTLE_CYC (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .power_up_req   (power_up_req),
        .power_down_req (power_down_req),
        .clr_fault      (clr_fault),
        .timeout_cycles (timeout_cycles),
        .rail_pgood     (rail_pgood),
        .rail_en        (rail_en),
        .rails_on       (rails_on),
        .busy           (busy),
        .fault          (fault),
        .fault_rail     (fault_rail)
    );

    function automatic logic [11:0] tup(logic [5:0] en, logic on, logic bs, logic f, logic [2:0] fr);
        return {en, on, bs, f, fr};
    endfunction

    task automatic push(string n, logic [11:0] v, int d);
        exp_t e;
        e.name = n;
        e.val  = v;
        e.dly  = d;
        q.push_back(e);
    endtask

    // Full ramp with pgood answering 3 cycles after each enable: 3 wait + 4 settle = 7 cycles per rail.
    task automatic push_up(string t);
        logic [5:0] en;
        push(t, tup(6'b000001, 1'b0, 1'b1, 1'b0, 3'd0), -1);
        for (int i = 1; i < N; i++) begin
            en = 6'((1 << (i + 1)) - 1);
            push(t, tup(en, 1'b0, 1'b1, 1'b0, 3'd0), 7);
        end
        push(t, tup(6'b111111, 1'b1, 1'b0, 1'b0, 3'd0), 7);
    endtask

    task automatic wait_drain(string tag, int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d expected changes still pending, want 0", tag, q.size());
            q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_en(logic [5:0] v, int budget);
        for (int i = 0; i < budget && rail_en !== v; i++) @(negedge clk);
    endtask

    // Rail model: pgood tracks rail_en with 3 cycles of ramp delay, minus stuck/glitched rails.
    initial begin
        hist       = '0;
        rail_pgood = '0;
        forever begin
            @(posedge clk);
            #1;
            hist[2]    = hist[1];
            hist[1]    = hist[0];
            hist[0]    = rail_en;
            rail_pgood = hist[2] & ~stuck & ~glitch;
        end
    end

    initial begin
        logic [11:0] cur, prev;
        exp_t        e;
        int          cyc, last;
        bit          first;
        cyc   = 0;
        last  = 0;
        first = 1'b1;
        prev  = '0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            cyc++;
            cur = {rail_en, rails_on, busy, fault, fault_rail};
            if (first || cur !== prev) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: got en=%b on=%b busy=%b fault=%b rail=%0d, want no change",
                             cur[11:6], cur[5], cur[4], cur[3], cur[2:0]);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.val || (e.dly >= 0 && (cyc - last) != e.dly)) begin
                        bad++;
                        $display("FAIL %s: got en=%b on=%b busy=%b fault=%b rail=%0d after %0d cyc, want en=%b on=%b busy=%b fault=%b rail=%0d after %0d cyc",
                                 e.name, cur[11:6], cur[5], cur[4], cur[3], cur[2:0], cyc - last,
                                 e.val[11:6], e.val[5], e.val[4], e.val[3], e.val[2:0], e.dly);
                    end
                end
                prev  = cur;
                last  = cyc;
                first = 1'b0;
            end
        end
    end

    initial begin
        rst            = 1'b1;
        power_up_req   = 1'b0;
        power_down_req = 1'b0;
        clr_fault      = 1'b0;
        timeout_cycles = 16'd10;
        stuck          = '0;
        glitch         = '0;
        repeat (3) @(negedge clk);
        push("reset", tup(6'b0, 1'b0, 1'b0, 1'b0, 3'd0), -1);
        rst    = 1'b0;
        mon_en = 1'b1;
        wait_drain("reset", 20);

        // Normal power-up
        push_up("up");
        power_up_req = 1'b1;
        wait_drain("up", 200);

        // Normal power-down, one rail every 3 cycles as pgood falls
        push("down_5", tup(6'b011111, 1'b0, 1'b1, 1'b0, 3'd0), -1);
        push("down_4", tup(6'b001111, 1'b0, 1'b1, 1'b0, 3'd0), 3);
        push("down_3", tup(6'b000111, 1'b0, 1'b1, 1'b0, 3'd0), 3);
        push("down_2", tup(6'b000011, 1'b0, 1'b1, 1'b0, 3'd0), 3);
        push("down_1", tup(6'b000001, 1'b0, 1'b1, 1'b0, 3'd0), 3);
        push("down_0", tup(6'b000000, 1'b0, 1'b1, 1'b0, 3'd0), 3);
        push("down_off", tup(6'b000000, 1'b0, 1'b0, 1'b0, 3'd0), 3);
        power_up_req   = 1'b0;
        power_down_req = 1'b1;
        wait_drain("down", 200);
        power_down_req = 1'b0;

        // Rail 2 never good: fault after 10 cycles in UP_WAIT; clr ignored while up requested
        stuck = 6'b000100;
        push("tmo_r0", tup(6'b000001, 1'b0, 1'b1, 1'b0, 3'd0), -1);
        push("tmo_r1", tup(6'b000011, 1'b0, 1'b1, 1'b0, 3'd0), 7);
        push("tmo_r2", tup(6'b000111, 1'b0, 1'b1, 1'b0, 3'd0), 7);
        push("tmo_fault", tup(6'b000000, 1'b0, 1'b0, 1'b1, 3'd2), 10);
        power_up_req = 1'b1;
        wait_drain("tmo", 200);
        clr_fault = 1'b1;
        repeat (3) @(negedge clk);
        clr_fault = 1'b0;
        push("tmo_clr", tup(6'b0, 1'b0, 1'b0, 1'b0, 3'd0), -1);
        power_up_req = 1'b0;
        clr_fault    = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        wait_drain("tmo_clr", 20);
        stuck = '0;

        // Brown-out of rail 4 for one cycle while ON
        push_up("bo_up");
        power_up_req = 1'b1;
        wait_drain("bo_up", 200);
        push("brownout", tup(6'b0, 1'b0, 1'b0, 1'b1, 3'd4), -1);
        glitch = 6'b010000;
        @(posedge clk);
        #2 glitch = '0;
        wait_drain("brownout", 20);
        push("bo_clr", tup(6'b0, 1'b0, 1'b0, 1'b0, 3'd0), -1);
        power_up_req = 1'b0;
        clr_fault    = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        wait_drain("bo_clr", 20);

        // Rails 3 and 5 drop in the same cycle a power-down is requested: fault wins, lowest index
        push_up("fd_up");
        power_up_req = 1'b1;
        wait_drain("fd_up", 200);
        push("fault_vs_down", tup(6'b0, 1'b0, 1'b0, 1'b1, 3'd3), -1);
        power_up_req = 1'b0;
        glitch = 6'b101000;
        @(posedge clk);
        #2 glitch = '0;
        power_down_req = 1'b1;
        @(posedge clk);
        #2 power_down_req = 1'b0;
        wait_drain("fault_vs_down", 20);
        push("fd_clr", tup(6'b0, 1'b0, 1'b0, 1'b0, 3'd0), -1);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        wait_drain("fd_clr", 20);

        // Abort while rail 3 settles: unwind 3,2,1,0; rails 4 and 5 never enabled
        push("ab_r0", tup(6'b000001, 1'b0, 1'b1, 1'b0, 3'd0), -1);
        push("ab_r1", tup(6'b000011, 1'b0, 1'b1, 1'b0, 3'd0), 7);
        push("ab_r2", tup(6'b000111, 1'b0, 1'b1, 1'b0, 3'd0), 7);
        push("ab_r3", tup(6'b001111, 1'b0, 1'b1, 1'b0, 3'd0), 7);
        push("ab_off3", tup(6'b000111, 1'b0, 1'b1, 1'b0, 3'd0), 5);
        push("ab_off2", tup(6'b000011, 1'b0, 1'b1, 1'b0, 3'd0), 3);
        push("ab_off1", tup(6'b000001, 1'b0, 1'b1, 1'b0, 3'd0), 3);
        push("ab_off0", tup(6'b000000, 1'b0, 1'b1, 1'b0, 3'd0), 3);
        push("ab_idle", tup(6'b000000, 1'b0, 1'b0, 1'b0, 3'd0), 3);
        power_up_req = 1'b1;
        wait_en(6'b001111, 200);
        repeat (4) @(negedge clk);
        power_up_req   = 1'b0;
        power_down_req = 1'b1;
        wait_drain("abort", 200);
        power_down_req = 1'b0;

        // timeout_cycles=0 never expires within 1000 cycles of a missing pgood
        timeout_cycles = 16'd0;
        stuck          = 6'b000010;
        push("t0_r0", tup(6'b000001, 1'b0, 1'b1, 1'b0, 3'd0), -1);
        push("t0_r1", tup(6'b000011, 1'b0, 1'b1, 1'b0, 3'd0), 7);
        power_up_req = 1'b1;
        wait_drain("t0_up", 200);
        repeat (1000) @(negedge clk);
        push("t0_off1", tup(6'b000001, 1'b0, 1'b1, 1'b0, 3'd0), -1);
        push("t0_off0", tup(6'b000000, 1'b0, 1'b1, 1'b0, 3'd0), 1);
        push("t0_idle", tup(6'b000000, 1'b0, 1'b0, 1'b0, 3'd0), 3);
        power_up_req   = 1'b0;
        power_down_req = 1'b1;
        wait_drain("t0_down", 200);
        power_down_req = 1'b0;
        timeout_cycles = 16'd10;
        stuck          = '0;

        // Reset in the middle of a ramp
        push("rst_r0", tup(6'b000001, 1'b0, 1'b1, 1'b0, 3'd0), -1);
        push("rst_r1", tup(6'b000011, 1'b0, 1'b1, 1'b0, 3'd0), 7);
        push("rst_r2", tup(6'b000111, 1'b0, 1'b1, 1'b0, 3'd0), 7);
        push("mid_reset", tup(6'b0, 1'b0, 1'b0, 1'b0, 3'd0), -1);
        power_up_req = 1'b1;
        wait_en(6'b000111, 200);
        @(negedge clk);
        rst          = 1'b1;
        power_up_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_drain("mid_reset", 50);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL final_queue: %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
